// File: rtl/cart_map_gen.sv
// cart_map_gen
//   Cart address mapper with runtime-programmable coprocessor windows, a
//   ROM fetch sequencer with a one-line read cache, and an ack watchdog.
//
//   State   | meaning
//   IDLE    | no ROM fetch outstanding; may issue a miss or a queued reissue
//   FETCH   | ROM_REQ held, waiting for ROM_ACK
//   PEND    | as FETCH, with one further line address queued for reissue
//
// Ports
//   CLK, RST                 clock, async active-high reset
//   CA, DI, DO               CPU address, write data, registered read data
//   CPURD_N, CPUWR_N         CPU strobes (not needed for the decode)
//   ROMSEL_N                 CPU ROM select
//   SYSCLKF_CE, SYSCLKR_CE   bus-cycle start / data strobes
//   MAP_CTRL, ROM_MASK,      map mode and address masks
//   BSRAM_MASK
//   CFG_*                    coprocessor window write port
//   SLOT_CS, SLOT_DO         coprocessor selects and read data
//   ROM_*                    ROM fetch handshake
//   BSRAM_*                  BSRAM address, enable, data
//   ROM_ERR                  sticky ROM-timeout flag
module cart_map_gen #(
  parameter int NSLOT   = 4,
  parameter int ROM_DW  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [23:0]        CA,
  input  logic [7:0]         DI,
  output logic [7:0]         DO,
  input  logic               CPURD_N,
  input  logic               CPUWR_N,
  input  logic               ROMSEL_N,
  input  logic               SYSCLKF_CE,
  input  logic               SYSCLKR_CE,
  input  logic [7:0]         MAP_CTRL,
  input  logic [23:0]        ROM_MASK,
  input  logic [23:0]        BSRAM_MASK,
  input  logic               CFG_WE,
  input  logic [2:0]         CFG_IDX,
  input  logic [23:0]        CFG_BASE,
  input  logic [23:0]        CFG_AMSK,
  input  logic               CFG_EN,
  output logic [NSLOT-1:0]   SLOT_CS,
  input  logic [8*NSLOT-1:0] SLOT_DO,
  output logic               ROM_REQ,
  output logic [23:0]        ROM_ADDR,
  input  logic               ROM_ACK,
  input  logic [ROM_DW-1:0]  ROM_Q,
  output logic [19:0]        BSRAM_ADDR,
  output logic               BSRAM_CE_N,
  output logic [7:0]         BSRAM_D,
  input  logic [7:0]         BSRAM_Q,
  output logic               ROM_ERR
);

  localparam int                NB         = ROM_DW / 8;
  localparam int                TMR_W      = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(TIMEOUT - 1);
  localparam logic [23:0]       OFS_MASK   = 24'(NB - 1);
  localparam logic [23:0]       ALIGN_MASK = ~OFS_MASK;

  typedef enum logic [1:0] {IDLE, FETCH, PEND} state_t;

  state_t             state;
  logic [23:0]        win_base [NSLOT];
  logic [23:0]        win_amsk [NSLOT];
  logic [NSLOT-1:0]   win_en;
  logic [NSLOT-1:0]   slot_cs;
  logic               slot_any;
  logic [7:0]         slot_dat;
  logic               bsram_hit;
  logic [19:0]        bsram_raw;
  logic               bsram_win;
  logic               rom_win;
  logic [23:0]        cart_addr;
  logic [23:0]        rom_byte_addr;
  logic [23:0]        line_addr;
  logic [23:0]        byte_ofs;
  logic [ROM_DW-1:0]  cache_data;
  logic [ROM_DW-1:0]  cache_shift;
  logic [23:0]        cache_tag;
  logic               cache_vld;
  logic               cache_hit;
  logic [23:0]        pend_addr;
  logic               reissue;
  logic [TMR_W-1:0]   tmr;
  logic [7:0]         map_q;
  logic [23:0]        mask_q;
  logic [7:0]         openbus;
  logic               unused_ok;

  assign unused_ok = ^{CPURD_N, CPUWR_N, BSRAM_MASK[23:20]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NSLOT; i++) begin
        win_base[i] <= '0;
        win_amsk[i] <= '0;
      end
      win_en <= '0;
    end else if (CFG_WE) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (CFG_IDX == 3'(i)) begin
          win_base[i] <= CFG_BASE;
          win_amsk[i] <= CFG_AMSK;
          win_en[i]   <= CFG_EN;
        end
      end
    end
  end

  // Lowest-numbered matching window wins.
  always_comb begin
    slot_cs  = '0;
    slot_any = 1'b0;
    slot_dat = 8'h00;
    for (int i = 0; i < NSLOT; i++) begin
      if (!slot_any && win_en[i] && ((CA ^ win_base[i]) & win_amsk[i]) == 24'h0) begin
        slot_cs[i] = 1'b1;
        slot_any   = 1'b1;
        slot_dat   = SLOT_DO[8*i +: 8];
      end
    end
  end

  // LoROM SRAM lives in banks 70-7D/F0-FF below 8000; Hi/ExHiROM at 6000-7FFF
  // of banks 20-3F/A0-BF.
  always_comb begin
    bsram_hit = 1'b0;
    bsram_raw = '0;
    cart_addr = '0;
    case (MAP_CTRL[1:0])
      2'd0: begin
        bsram_hit = (CA[22:20] == 3'b111) && !CA[15] && (CA[23] || CA[19:17] != 3'b111);
        bsram_raw = {1'b0, CA[19:16], CA[14:0]};
        cart_addr = {1'b0, ~CA[23], CA[22:16], CA[14:0]};
      end
      2'd2: begin
        bsram_hit = !CA[22] && CA[21] && (CA[15:13] == 3'b011);
        bsram_raw = {2'b00, CA[20:16], CA[12:0]};
        cart_addr = {1'b0, ~CA[23], CA[21:0]};
      end
      default: begin
        bsram_hit = !CA[22] && CA[21] && (CA[15:13] == 3'b011);
        bsram_raw = {2'b00, CA[20:16], CA[12:0]};
        cart_addr = {2'b00, CA[21:0]};
      end
    endcase
  end

  assign bsram_win     = bsram_hit && !slot_any;
  assign rom_win       = !slot_any && !bsram_hit && !ROMSEL_N;
  assign SLOT_CS       = slot_cs;
  assign BSRAM_CE_N    = !bsram_win;
  assign BSRAM_ADDR    = bsram_raw & BSRAM_MASK[19:0];
  assign BSRAM_D       = DI;

  assign rom_byte_addr = cart_addr & ROM_MASK;
  assign line_addr     = rom_byte_addr & ALIGN_MASK;
  assign byte_ofs      = rom_byte_addr & OFS_MASK;
  assign cache_shift   = cache_data >> {byte_ofs, 3'b000};
  assign cache_hit     = cache_vld && (cache_tag == line_addr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      ROM_REQ    <= 1'b0;
      ROM_ADDR   <= '0;
      ROM_ERR    <= 1'b0;
      tmr        <= '0;
      cache_vld  <= 1'b0;
      cache_tag  <= '0;
      cache_data <= '0;
      pend_addr  <= '0;
      reissue    <= 1'b0;
      map_q      <= '0;
      mask_q     <= '0;
    end else begin
      map_q  <= MAP_CTRL;
      mask_q <= ROM_MASK;
      case (state)
        IDLE: begin
          if (reissue) begin
            reissue  <= 1'b0;
            ROM_REQ  <= 1'b1;
            ROM_ADDR <= pend_addr;
            tmr      <= TMR_LOAD;
            state    <= FETCH;
          end else if (SYSCLKF_CE && rom_win && !cache_hit) begin
            ROM_REQ  <= 1'b1;
            ROM_ADDR <= line_addr;
            tmr      <= TMR_LOAD;
            state    <= FETCH;
          end
        end
        FETCH, PEND: begin
          if (ROM_ACK) begin
            cache_data <= ROM_Q;
            cache_tag  <= ROM_ADDR;
            cache_vld  <= 1'b1;
            ROM_REQ    <= 1'b0;
            reissue    <= (state == PEND);
            state      <= IDLE;
          end else if (tmr == '0) begin
            ROM_REQ   <= 1'b0;
            cache_vld <= 1'b0;
            ROM_ERR   <= 1'b1;
            state     <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
            if (SYSCLKF_CE && rom_win && line_addr != ROM_ADDR) begin
              pend_addr <= line_addr;
              state     <= PEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A mapping change wins over a same-cycle fill.
      if (map_q != MAP_CTRL || mask_q != ROM_MASK)
        cache_vld <= 1'b0;
    end
  end

  // A ROM read that is still outstanding (or missed) returns open bus.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DO      <= 8'hFF;
      openbus <= 8'hFF;
    end else if (SYSCLKR_CE) begin
      openbus <= DI;
      if (slot_any)
        DO <= slot_dat;
      else if (bsram_win)
        DO <= BSRAM_Q;
      else if (rom_win && state == IDLE && cache_hit)
        DO <= cache_shift[7:0];
      else
        DO <= openbus;
    end
  end

endmodule

// File: tb/tb_cart_map_gen.sv
module tb_cart_map_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic [23:0] CA;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        CPURD_N, CPUWR_N, ROMSEL_N, SYSCLKF_CE, SYSCLKR_CE;
  logic [7:0]  MAP_CTRL;
  logic [23:0] ROM_MASK, BSRAM_MASK;
  logic        CFG_WE;
  logic [2:0]  CFG_IDX;
  logic [23:0] CFG_BASE, CFG_AMSK;
  logic        CFG_EN;
  logic [3:0]  SLOT_CS;
  logic [31:0] SLOT_DO;
  logic        ROM_REQ;
  logic [23:0] ROM_ADDR;
  logic        ROM_ACK;
  logic [15:0] ROM_Q;
  logic [19:0] BSRAM_ADDR;
  logic        BSRAM_CE_N;
  logic [7:0]  BSRAM_D;
  logic [7:0]  BSRAM_Q;
  logic        ROM_ERR;

  int checks = 0;
  int failures = 0;
  int n_req = 0;
  bit          m_vld = 0;
  logic [23:0] m_line = '0;

  cart_map_gen #(.NSLOT(4), .ROM_DW(16), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST), .CA(CA), .DI(DI), .DO(DO),
    .CPURD_N(CPURD_N), .CPUWR_N(CPUWR_N), .ROMSEL_N(ROMSEL_N),
    .SYSCLKF_CE(SYSCLKF_CE), .SYSCLKR_CE(SYSCLKR_CE),
    .MAP_CTRL(MAP_CTRL), .ROM_MASK(ROM_MASK), .BSRAM_MASK(BSRAM_MASK),
    .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX), .CFG_BASE(CFG_BASE), .CFG_AMSK(CFG_AMSK),
    .CFG_EN(CFG_EN), .SLOT_CS(SLOT_CS), .SLOT_DO(SLOT_DO),
    .ROM_REQ(ROM_REQ), .ROM_ADDR(ROM_ADDR), .ROM_ACK(ROM_ACK), .ROM_Q(ROM_Q),
    .BSRAM_ADDR(BSRAM_ADDR), .BSRAM_CE_N(BSRAM_CE_N), .BSRAM_D(BSRAM_D),
    .BSRAM_Q(BSRAM_Q), .ROM_ERR(ROM_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  // Backing ROM contents: bytes 0/1 are the fixed AA/BB pair.
  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    logic [23:0] t;
    if (a == 24'h0) return 8'hAA;
    if (a == 24'h1) return 8'hBB;
    t = a ^ {a[7:0], a[23:8]};
    return t[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [15:0] rom_word(input logic [23:0] line);
    return {rom_byte(line + 24'd1), rom_byte(line)};
  endfunction

  function automatic logic [23:0] model_cart(input logic [23:0] ca, input logic [1:0] mode);
    int bank, off, r;
    bank = int'(ca[23:16]);
    off  = int'(ca[15:0]);
    case (mode)
      2'd0:    r = (bank & 'h7F) * 'h8000 + (off & 'h7FFF) + ((bank >= 'h80) ? 0 : 'h400000);
      2'd2:    r = (int'(ca) & 'h3FFFFF) + ((bank >= 'h80) ? 0 : 'h400000);
      default: r = int'(ca) & 'h3FFFFF;
    endcase
    return 24'(r) & ROM_MASK;
  endfunction

  task automatic pulse_r();
    SYSCLKR_CE = 1'b1;
    @(negedge CLK);
    SYSCLKR_CE = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input logic [23:0] base, input logic [23:0] amsk, input bit en);
    @(negedge CLK);
    CFG_IDX = 3'(idx); CFG_BASE = base; CFG_AMSK = amsk; CFG_EN = en; CFG_WE = 1'b1;
    @(negedge CLK);
    CFG_WE = 1'b0;
  endtask

  task automatic do_read(input logic [23:0] ca, input int dly);
    logic [23:0] cart, line;
    bit hit;
    cart = model_cart(ca, MAP_CTRL[1:0]);
    line = cart & ~24'h1;
    hit  = m_vld && (m_line == line);
    @(negedge CLK);
    CA = ca; ROMSEL_N = 1'b0; CPURD_N = 1'b0; SYSCLKF_CE = 1'b1;
    @(negedge CLK);
    SYSCLKF_CE = 1'b0;
    checks++;
    if (ROM_REQ !== !hit) begin
      failures++;
      $display("FAIL read_req ca=%h: got %b expected %b", ca, ROM_REQ, !hit);
    end
    if (ROM_REQ === 1'b1) begin
      n_req++;
      checks++;
      if (ROM_ADDR !== line) begin
        failures++;
        $display("FAIL read_addr ca=%h: got %h expected %h", ca, ROM_ADDR, line);
      end
      repeat (dly) @(negedge CLK);
      checks++;
      if (ROM_REQ !== 1'b1 || ROM_ADDR !== line) begin
        failures++;
        $display("FAIL req_hold ca=%h: got %b/%h expected 1/%h", ca, ROM_REQ, ROM_ADDR, line);
      end
      ROM_Q = rom_word(line); ROM_ACK = 1'b1;
      @(negedge CLK);
      ROM_ACK = 1'b0;
      checks++;
      if (ROM_REQ !== 1'b0) begin
        failures++;
        $display("FAIL req_drop ca=%h: got %b expected 0", ca, ROM_REQ);
      end
      m_vld = 1; m_line = line;
    end
    pulse_r();
    checks++;
    if (DO !== rom_byte(cart)) begin
      failures++;
      $display("FAIL read_do ca=%h: got %h expected %h", ca, DO, rom_byte(cart));
    end
    ROMSEL_N = 1'b1; CPURD_N = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1; CA = '0; DI = '0; CPURD_N = 1; CPUWR_N = 1; ROMSEL_N = 1;
    SYSCLKF_CE = 0; SYSCLKR_CE = 0; MAP_CTRL = 8'h00; ROM_MASK = 24'h3FFFFF;
    BSRAM_MASK = 24'h0FFFFF; CFG_WE = 0; CFG_IDX = 0; CFG_BASE = 0; CFG_AMSK = 0;
    CFG_EN = 0; SLOT_DO = 32'h44332211; ROM_ACK = 0; ROM_Q = 0; BSRAM_Q = 8'h3C;
    repeat (3) @(negedge CLK);
    checks++;
    if (DO !== 8'hFF || ROM_REQ !== 1'b0 || SLOT_CS !== 4'h0 || ROM_ERR !== 1'b0 ||
        BSRAM_CE_N !== 1'b1 || ROM_ADDR !== 24'h0) begin
      failures++;
      $display("FAIL reset: got DO=%h REQ=%b CS=%h ERR=%b CE_N=%b ADDR=%h expected FF 0 0 0 1 000000",
               DO, ROM_REQ, SLOT_CS, ROM_ERR, BSRAM_CE_N, ROM_ADDR);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    m_vld = 0;
  endtask

  task automatic test_lorom_fetch();
    int r0;
    r0 = n_req;
    do_read(24'h008000, 3);
    do_read(24'h008001, 3);
    checks++;
    if (n_req - r0 != 1) begin
      failures++;
      $display("FAIL lorom_req_count: got %0d expected 1", n_req - r0);
    end
  endtask

  task automatic test_slots();
    logic [3:0] exp_cs;
    logic [7:0] exp_do;
    logic [23:0] base [4];
    logic [23:0] amsk [4];
    bit en [4];
    cfg_write(0, 24'h006000, 24'h40E000, 1);
    cfg_write(2, 24'h000000, 24'h000000, 1);
    CA = 24'h806123;
    #1;
    checks++;
    if (SLOT_CS !== 4'b0001) begin
      failures++;
      $display("FAIL slot_prio: got %b expected 0001", SLOT_CS);
    end
    @(negedge CLK);
    pulse_r();
    checks++;
    if (DO !== SLOT_DO[7:0]) begin
      failures++;
      $display("FAIL slot_do: got %h expected %h", DO, SLOT_DO[7:0]);
    end
    cfg_write(0, 24'h006000, 24'h40E000, 0);
    #1;
    checks++;
    if (SLOT_CS !== 4'b0100) begin
      failures++;
      $display("FAIL slot_disable: got %b expected 0100", SLOT_CS);
    end
    for (int k = 0; k < 4; k++) begin
      base[k] = 24'($urandom) & 24'h00F0F0;
      amsk[k] = 24'($urandom) & 24'h00F0F0;
      en[k]   = 1'($urandom);
      cfg_write(k, base[k], amsk[k], en[k]);
    end
    for (int n = 0; n < 16; n++) begin
      @(negedge CLK);
      CA = 24'($urandom) & 24'h00F0F0;
      SLOT_DO = $urandom;
      exp_cs = 4'h0; exp_do = 8'h00;
      for (int k = 3; k >= 0; k--)
        if (en[k] && ((CA ^ base[k]) & amsk[k]) == 24'h0) begin
          exp_cs = 4'h0; exp_cs[k] = 1'b1; exp_do = SLOT_DO[8*k +: 8];
        end
      #1;
      checks++;
      if (SLOT_CS !== exp_cs) begin
        failures++;
        $display("FAIL slot_rand ca=%h: got %b expected %b", CA, SLOT_CS, exp_cs);
      end
      if (exp_cs != 4'h0) begin
        @(negedge CLK);
        pulse_r();
        checks++;
        if (DO !== exp_do) begin
          failures++;
          $display("FAIL slot_rand_do ca=%h: got %h expected %h", CA, DO, exp_do);
        end
      end
    end
    for (int k = 0; k < 4; k++) cfg_write(k, 24'h0, 24'h0, 0);
  endtask

  task automatic test_bsram();
    @(negedge CLK);
    MAP_CTRL = 8'h00; CA = 24'h711234; ROMSEL_N = 1'b0; SYSCLKF_CE = 1'b1;
    @(negedge CLK);
    SYSCLKF_CE = 1'b0;
    checks++;
    if (BSRAM_CE_N !== 1'b0 || BSRAM_ADDR !== 20'h09234 || ROM_REQ !== 1'b0 || SLOT_CS !== 4'h0) begin
      failures++;
      $display("FAIL bsram_lorom: got CE_N=%b ADDR=%h REQ=%b expected 0 09234 0", BSRAM_CE_N, BSRAM_ADDR, ROM_REQ);
    end
    pulse_r();
    checks++;
    if (DO !== 8'h3C) begin
      failures++;
      $display("FAIL bsram_do: got %h expected 3C", DO);
    end
    MAP_CTRL = 8'h01; CA = 24'h306123;
    #1;
    checks++;
    if (BSRAM_CE_N !== 1'b0 || BSRAM_ADDR !== 20'h20123) begin
      failures++;
      $display("FAIL bsram_hirom: got CE_N=%b ADDR=%h expected 0 20123", BSRAM_CE_N, BSRAM_ADDR);
    end
    @(negedge CLK);
    MAP_CTRL = 8'h00; ROMSEL_N = 1'b1;
    repeat (2) @(negedge CLK);
    m_vld = 0;
  endtask

  task automatic test_timeout();
    int cnt;
    DI = 8'h5C; CA = 24'h000000;
    @(negedge CLK);
    pulse_r();
    CA = 24'h00C000; ROMSEL_N = 1'b0; SYSCLKF_CE = 1'b1;
    @(negedge CLK);
    SYSCLKF_CE = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (ROM_REQ !== 1'b1) break;
      cnt++;
      @(negedge CLK);
    end
    checks++;
    if (cnt != 64) begin
      failures++;
      $display("FAIL timeout_len: got %0d expected 64", cnt);
    end
    checks++;
    if (ROM_ERR !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err: got %b expected 1", ROM_ERR);
    end
    pulse_r();
    checks++;
    if (DO !== 8'h5C) begin
      failures++;
      $display("FAIL timeout_do: got %h expected 5C", DO);
    end
    ROMSEL_N = 1'b1;
    m_vld = 0;
    do_read(24'h008000, 2);
    checks++;
    if (ROM_ERR !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: got %b expected 1", ROM_ERR);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    CA = 24'h00A000; ROMSEL_N = 1'b0; SYSCLKF_CE = 1'b1;
    @(negedge CLK);
    CA = 24'h018000;
    @(negedge CLK);
    SYSCLKF_CE = 1'b0;
    checks++;
    if (ROM_REQ !== 1'b1 || ROM_ADDR !== 24'h002000) begin
      failures++;
      $display("FAIL pend_first: got %b/%h expected 1/002000", ROM_REQ, ROM_ADDR);
    end
    ROM_Q = rom_word(24'h002000); ROM_ACK = 1'b1;
    @(negedge CLK);
    ROM_ACK = 1'b0;
    checks++;
    if (ROM_REQ !== 1'b0) begin
      failures++;
      $display("FAIL pend_drop: got %b expected 0", ROM_REQ);
    end
    @(negedge CLK);
    checks++;
    if (ROM_REQ !== 1'b1 || ROM_ADDR !== 24'h008000) begin
      failures++;
      $display("FAIL pend_reissue: got %b/%h expected 1/008000", ROM_REQ, ROM_ADDR);
    end
    ROM_Q = rom_word(24'h008000); ROM_ACK = 1'b1;
    @(negedge CLK);
    ROM_ACK = 1'b0;
    m_vld = 1; m_line = 24'h008000;
    pulse_r();
    checks++;
    if (DO !== rom_byte(24'h008000)) begin
      failures++;
      $display("FAIL pend_do: got %h expected %h", DO, rom_byte(24'h008000));
    end
    ROMSEL_N = 1'b1;
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge CLK);
    CA = 24'h00E000; ROMSEL_N = 1'b0; SYSCLKF_CE = 1'b1;
    @(negedge CLK);
    SYSCLKF_CE = 1'b0;
    checks++;
    if (ROM_REQ !== 1'b1) begin
      failures++;
      $display("FAIL rst_fetch_start: got %b expected 1", ROM_REQ);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (ROM_REQ !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_req: got %b expected 0", ROM_REQ);
    end
    @(negedge CLK);
    RST = 1'b0;
    ROM_Q = 16'hDEAD; ROM_ACK = 1'b1;
    @(negedge CLK);
    ROM_ACK = 1'b0;
    checks++;
    if (ROM_REQ !== 1'b0 || ROM_ERR !== 1'b0) begin
      failures++;
      $display("FAIL rst_late_ack: got REQ=%b ERR=%b expected 0 0", ROM_REQ, ROM_ERR);
    end
    ROMSEL_N = 1'b1;
    m_vld = 0;
    do_read(24'h00E000, 1);
  endtask

  task automatic test_random_reads();
    int bank, off;
    logic [23:0] ca;
    for (int i = 0; i < 40; i++) begin
      if (i == 20 || i == 30) begin
        @(negedge CLK);
        MAP_CTRL = (i == 20) ? 8'h01 : 8'h02;
        repeat (2) @(negedge CLK);
        m_vld = 0;
      end
      bank = $urandom_range(0, 1);
      off  = $urandom_range(0, 5);
      if (MAP_CTRL[1:0] == 2'd0) ca = {8'(bank), 16'h8000 + 16'(off)};
      else                       ca = {8'(8'hC0 + bank), 16'(off)};
      do_read(ca, $urandom_range(0, 4));
    end
  endtask

  initial begin
    test_reset();
    test_lorom_fetch();
    test_slots();
    test_bsram();
    test_timeout();
    test_back_to_back();
    test_reset_mid_fetch();
    test_random_reads();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
